// File: rtl/sb_param_cfg_shadow.sv
// sb_param_cfg_shadow
// Switch-block routing core: NUM_OUT muxes of MUX_SIZE:1 whose selects come
// from a serial configuration chain. Bits shift into a shadow register; a
// validated commit copies the shadow into the active select register in one
// edge, so the routing never sees a half-loaded configuration.
//
// Ports
//   prog_clk    configuration clock (only clock)
//   prog_reset  asynchronous active-high reset
//   ccff_head   serial configuration data in
//   ccff_en     shift enable
//   cfg_commit  commit request
//   mux_in      mux candidates, mux k input j = mux_in[k*MUX_SIZE+j]
//   chan_out    routed outputs (0 until the first valid commit)
//   ccff_tail   serial data out to the next block in the chain
//   cfg_count   bits shifted since last commit/reset (saturating)
//   cfg_done    cfg_count == CFG_BITS
//   cfg_valid   at least one successful commit since reset
//   commit_err  one-cycle pulse after a rejected commit
//   sel_err     some active select is >= MUX_SIZE
module sb_param_cfg_shadow #(
  parameter int NUM_OUT  = 16,
  parameter int MUX_SIZE = 4,
  localparam int SEL_W    = $clog2(MUX_SIZE),
  localparam int CFG_BITS = NUM_OUT * SEL_W,
  localparam int CNT_W    = $clog2(CFG_BITS + 1)
) (
  input  logic                        prog_clk,
  input  logic                        prog_reset,
  input  logic                        ccff_head,
  input  logic                        ccff_en,
  input  logic                        cfg_commit,
  input  logic [NUM_OUT*MUX_SIZE-1:0] mux_in,
  output logic [NUM_OUT-1:0]          chan_out,
  output logic                        ccff_tail,
  output logic [CNT_W-1:0]            cfg_count,
  output logic                        cfg_done,
  output logic                        cfg_valid,
  output logic                        commit_err,
  output logic                        sel_err
);

  logic [CFG_BITS-1:0] shadow;
  logic [CFG_BITS-1:0] active;

  assign cfg_done  = (cfg_count == CNT_W'(CFG_BITS));
  assign ccff_tail = shadow[CFG_BITS-1];

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      shadow     <= '0;
      active     <= '0;
      cfg_count  <= '0;
      cfg_valid  <= 1'b0;
      commit_err <= 1'b0;
    end else begin
      commit_err <= 1'b0;
      if (ccff_en) begin
        // Shift form avoids an empty slice when the chain is a single bit.
        shadow <= (shadow << 1) | CFG_BITS'(ccff_head);
        if (!cfg_done)
          cfg_count <= cfg_count + CNT_W'(1);
        // A commit overlapping a shift is rejected; the shift still happens.
        if (cfg_commit)
          commit_err <= 1'b1;
      end else if (cfg_commit) begin
        if (cfg_done) begin
          active    <= shadow;
          cfg_count <= '0;
          cfg_valid <= 1'b1;
        end else begin
          commit_err <= 1'b1;
        end
      end
    end
  end

  // Select decode compares against each legal input index, so an
  // out-of-range select simply matches nothing and the output stays 0.
  always_comb begin
    logic [SEL_W-1:0] sel;
    sel      = '0;
    chan_out = '0;
    sel_err  = 1'b0;
    for (int k = 0; k < NUM_OUT; k++) begin
      sel = active[k*SEL_W +: SEL_W];
      if (int'(sel) >= MUX_SIZE)
        sel_err = 1'b1;
      for (int j = 0; j < MUX_SIZE; j++) begin
        if (cfg_valid && (int'(sel) == j))
          chan_out[k] = mux_in[k*MUX_SIZE + j];
      end
    end
  end

endmodule
